// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC register with branch/jump resolution, flush bubbles and misalign halt
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        flush,
  output logic        misalign_err,
  output logic        halted
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [31:0] target;
  logic cond, mis;
  // branch condition, compare mode and redirect target
  always_comb begin
    BrUn = funct3[2] & funct3[1];
    cond = funct3[2] ? (BrLT ^ funct3[0]) : (~funct3[1] & (BrEq ^ funct3[0]));
    target = is_jalr ? {alu_result[31:1], 1'b0} : pc_ex + imm;
    mis = target[1:0] != 2'b00;
    pc_plus4 = pc + 32'd4;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_n;
  // next-state logic
  always_comb
    state_n = state == RUN ? (taken ? (mis ? HALT : FLUSH) : RUN) :
              state == FLUSH ? (cnt == 3'd0 ? RUN : FLUSH) : HALT;
  // state-dependent outputs
  always_comb begin
    taken = state == RUN && ex_valid && (is_jal || is_jalr || (is_branch && cond));
    flush = taken || state == FLUSH;
    halted = state == HALT;
  end
  // pc, bubble counter and misalign pulse
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      cnt <= 3'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= taken && mis;
      if (taken) begin
        if (!mis) begin
          pc <= target;
          cnt <= 3'(FLUSH_CYCLES - 1);
        end
      end else begin
        if (!stall && state != HALT) pc <= pc_plus4;
        if (state == FLUSH && cnt != 3'd0) cnt <= cnt - 3'd1;
      end
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed vectors with scoreboard queue and negedge monitor
module tb_pc_branch_unit;
  logic clk = 0, rst = 1, stall = 0, ex_valid = 0, is_branch = 0, is_jal = 0, is_jalr = 0;
  logic [2:0] funct3 = 0;
  logic BrEq = 0, BrLT = 0, BrUn;
  logic [31:0] pc_ex = 0, imm = 0, alu_result = 0, pc, pc_plus4;
  logic taken, flush, misalign_err, halted;
  int checks = 0, failures = 0;
  typedef struct {string n; logic [31:0] pc; logic fl, tk, h, m, bu;} exp_t;
  exp_t q[$];

  pc_branch_unit dut (.clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .pc_ex(pc_ex), .imm(imm),
    .alu_result(alu_result), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
    .flush(flush), .misalign_err(misalign_err), .halted(halted));

  always #5 clk = ~clk;

  task automatic cyc(input string n, input logic [31:0] epc, input logic efl, input logic etk,
                     input logic eh, input logic em, input logic ebu);
    exp_t e;
    e.n = n; e.pc = epc; e.fl = efl; e.tk = etk; e.h = eh; e.m = em; e.bu = ebu;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic b, input logic j, input logic jr);
    ex_valid = v; is_branch = b; is_jal = j; is_jalr = jr;
  endtask

  initial begin
    exp_t e;
    logic [31:0] ep4;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        ep4 = e.pc + 32'd4;
        checks++;
        if (pc !== e.pc || pc_plus4 !== ep4 || flush !== e.fl || taken !== e.tk ||
            halted !== e.h || misalign_err !== e.m || BrUn !== e.bu) begin
          failures++;
          $display("FAIL %s: pc=%h p4=%h fl=%b tk=%b h=%b m=%b bu=%b required pc=%h p4=%h fl=%b tk=%b h=%b m=%b bu=%b",
            e.n, pc, pc_plus4, flush, taken, halted, misalign_err, BrUn,
            e.pc, ep4, e.fl, e.tk, e.h, e.m, e.bu);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    rst = 0;
    cyc("reset", 32'h0, 0, 0, 0, 0, 0);
    cyc("run4", 32'h4, 0, 0, 0, 0, 0);
    cyc("run8", 32'h8, 0, 0, 0, 0, 0);
    cyc("run12", 32'hC, 0, 0, 0, 0, 0);
    ex(1, 1, 0, 0); funct3 = 3'b000; BrEq = 1; pc_ex = 32'h100; imm = 32'h20;
    cyc("beq_taken", 32'h10, 1, 1, 0, 0, 0);
    ex(1, 0, 1, 0);
    cyc("flush1_jal_ignored", 32'h120, 1, 0, 0, 0, 0);
    cyc("flush2_jal_ignored", 32'h124, 1, 0, 0, 0, 0);
    ex(0, 0, 0, 0);
    cyc("back_run", 32'h128, 0, 0, 0, 0, 0);
    ex(1, 1, 0, 0); BrEq = 0;
    cyc("beq_not_taken", 32'h12C, 0, 0, 0, 0, 0);
    funct3 = 3'b100; BrLT = 0;
    cyc("blt_not_taken_brun0", 32'h130, 0, 0, 0, 0, 0);
    ex(0, 0, 0, 0); stall = 1;
    cyc("stall_a", 32'h134, 0, 0, 0, 0, 0);
    cyc("stall_b", 32'h134, 0, 0, 0, 0, 0);
    ex(1, 1, 0, 0); funct3 = 3'b110; BrLT = 1; pc_ex = 32'h200; imm = 32'h40;
    cyc("bltu_under_stall", 32'h134, 1, 1, 0, 0, 1);
    ex(0, 0, 0, 0);
    cyc("flush_stalled", 32'h240, 1, 0, 0, 0, 1);
    stall = 0;
    cyc("flush_counts_through_stall", 32'h240, 1, 0, 0, 0, 1);
    funct3 = 3'b000;
    cyc("run_after_bltu", 32'h244, 0, 0, 0, 0, 0);
    ex(0, 0, 1, 0); ex_valid = 1; pc_ex = 32'hFFFF_FFF0; imm = 32'h20;
    cyc("jal_wrap", 32'h248, 1, 1, 0, 0, 0);
    ex(0, 0, 0, 0);
    cyc("jal_wrap_f1", 32'h10, 1, 0, 0, 0, 0);
    cyc("jal_wrap_f2", 32'h14, 1, 0, 0, 0, 0);
    ex(1, 0, 1, 0); pc_ex = 32'h1000; imm = 32'h0;
    cyc("jal2", 32'h18, 1, 1, 0, 0, 0);
    ex(0, 0, 0, 0); rst = 1;
    cyc("rst_mid_flush", 32'h1000, 1, 0, 0, 0, 0);
    rst = 0;
    cyc("post_rst", 32'h0, 0, 0, 0, 0, 0);
    ex(1, 0, 1, 0); pc_ex = 32'hFFFF_FFF0; imm = 32'h8;
    cyc("jal_top", 32'h4, 1, 1, 0, 0, 0);
    ex(0, 0, 0, 0);
    cyc("top_f1", 32'hFFFF_FFF8, 1, 0, 0, 0, 0);
    cyc("top_f2_p4wrap", 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    cyc("pc_wrapped", 32'h0, 0, 0, 0, 0, 0);
    ex(1, 0, 0, 1); alu_result = 32'h203;
    cyc("jalr_misaligned", 32'h4, 1, 1, 0, 0, 0);
    ex(0, 0, 0, 0);
    cyc("halt_pulse", 32'h4, 0, 0, 1, 1, 0);
    cyc("halt_hold", 32'h4, 0, 0, 1, 0, 0);
    ex(1, 0, 1, 0);
    cyc("halt_ignores_jal", 32'h4, 0, 0, 1, 0, 0);
    ex(0, 0, 0, 0); rst = 1;
    cyc("halt_rst", 32'h4, 0, 0, 1, 0, 0);
    rst = 0;
    cyc("after_halt_rst", 32'h0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of bubble cycles after a redirect (legal range 1..7).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  hold PC (fetch back-pressure).
REQ-006 SHALL have port ex_valid  in  1  EX-stage instruction valid.
REQ-007 SHALL have ports is_branch, is_jal, is_jalr  in  1 each  EX instruction class (at most one set).
REQ-008 SHALL have port funct3  in  3  branch type of EX instruction.
REQ-009 SHALL have ports BrEq, BrLT  in  1 each  comparator results for EX operands.
REQ-010 SHALL have port BrUn  out  1  compare mode to comparator; 1 = unsigned.
REQ-011 SHALL have ports pc_ex, imm, alu_result  in  32 each  EX PC, immediate, ALU sum (JALR target).
REQ-012 SHALL have ports pc, pc_plus4  out  32 each  fetch PC and pc+4.
REQ-013 SHALL have ports taken, flush, misalign_err, halted  out  1 each.

Function
REQ-014 BrUn SHALL be combinational: 1 iff funct3 is 110 or 111, else 0.
REQ-015 Branch condition SHALL be: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT; 010/011 never taken.
REQ-016 taken SHALL be combinational: state RUN and ex_valid and (is_jal or is_jalr or (is_branch and condition)).
REQ-017 Target SHALL be pc_ex+imm for branch/JAL, alu_result with bit 0 cleared for JALR; 32-bit addition, wraps modulo 2^32, no overflow flag.
REQ-018 States SHALL be RUN, FLUSH, HALT; encoding left to implementer.
REQ-019 RUN, taken, target[1:0]==00: next-edge pc <= target, state <= FLUSH, flush counter <= FLUSH_CYCLES-1.
REQ-020 RUN, taken, target[1:0]!=00: pc unchanged, misalign_err high exactly one cycle (registered), state <= HALT.
REQ-021 RUN, not taken: pc <= pc+4 if stall==0, else hold.
REQ-022 Redirect SHALL take priority over stall (a taken redirect updates pc even with stall=1).
REQ-023 flush SHALL be high in the redirect cycle (combinational with taken) and in every FLUSH cycle; low otherwise.
REQ-024 FLUSH: ex_valid/is_* ignored, taken=0; pc <= pc+4 unless stall; counter decrements each cycle regardless of stall; at counter==0 state <= RUN.
REQ-025 HALT: pc held, taken=0, flush=0, halted=1; exit only via rst.
REQ-026 pc_plus4 SHALL equal pc+4 combinationally, wrapping 32'hFFFF_FFFC -> 0.
REQ-027 pc+4 increment SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-028 On clk edge with rst=1: pc=RESET_PC, state RUN, counter 0, misalign_err=0, halted=0; overrides any concurrent redirect, stall or HALT.
REQ-029 Combinational outputs after reset: flush=0, taken=0 unless RUN-state redirect conditions hold.

Verification
REQ-030 Reset then 3 cycles stall=0, no ex_valid -> pc 0, 4, 8, 12.
REQ-031 pc_ex=0x100, imm=0x20, is_branch, funct3=000, BrEq=1 -> taken=1, flush=1, next pc=0x120, flush high 2 more cycles, then RUN; same with BrEq=0 -> pc+4.
REQ-032 funct3=110 -> BrUn=1; funct3=100 -> BrUn=0; BLTU with BrLT=1, stall=1 -> redirect still applied.
REQ-033 is_jalr, alu_result=0x203 -> pc=0x202? no: 0x202 misaligned -> misalign_err one-cycle pulse, halted=1, pc frozen until rst.
REQ-034 pc_ex=0xFFFF_FFF0, imm=0x20 JAL -> pc=0x0000_0010; pc=0xFFFF_FFFC free-running -> 0.
REQ-035 Redirect during FLUSH (ex_valid, is_jal) -> ignored; rst asserted mid-FLUSH -> pc=RESET_PC, flush=0 next cycle.
